uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver for 8N1-style serial frames. It consumes the 16x oversampling tick produced by the team's baud generator and recovers bytes from the asynchronous rx line by sampling at bit centres. It delivers each byte with a one-cycle done strobe and flags framing errors. It sits between the board rx pin and the consumer logic (FIFO or command decoder) in the UART subsystem.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9
SYNC_STAGES, 2, flip-flop stages in the rx input synchronizer; minimum 2

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset, asynchronous, active-high
b_tick  input  1  16x oversample tick; one-clk pulse at BAUD*16 rate
rx  input  1  asynchronous serial line; idle high
rx_data  output  DATA_BITS  last correctly framed byte; held until the next valid frame
rx_done  output  1  one-clk pulse when rx_data updates
frame_err  output  1  one-clk pulse when the stop bit samples low
rx_busy  output  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-high, on clk; clk is the only clock. Reset values: rx_data=0, rx_done=0, frame_err=0, rx_busy=0, FSM=IDLE, counters=0, synchronizer stages=1 (line idle).
- rx passes through SYNC_STAGES flip-flops. All decisions use the synchronized value rx_s.
- The tick counter is 4 bits (tick_cnt) and advances only on cycles with b_tick=1. The bit counter is $clog2(DATA_BITS+1) bits (bit_cnt). The shift register is DATA_BITS wide.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rx_s=0, go to START with tick_cnt=0. This needs no b_tick.
- START: on b_tick with tick_cnt=7 (start-bit centre):
  - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1: false start (glitch); go to IDLE with no output.
  - On any other b_tick, tick_cnt increments.
- DATA: on b_tick with tick_cnt=15:
  - Shift rx_s in at the MSB and shift right, so the first bit lands in the LSB after DATA_BITS shifts.
  - tick_cnt wraps to 0 and bit_cnt increments.
  - When bit_cnt=DATA_BITS-1 at this sample, go to STOP.
- STOP: on b_tick with tick_cnt=15 (stop-bit centre):
  - rx_s=1: rx_data gets the shift register, rx_done=1 for the next clk only, go to IDLE.
  - rx_s=0: frame_err=1 for the next clk only, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition (continuous low) from retriggering frames.
- Latency: rx_done and frame_err are registered and rise on the clk edge after the b_tick that samples the stop bit.
- Returning to IDLE at the stop-bit centre is deliberate; it allows back-to-back frames with a single stop bit.
- rx_done and frame_err are never asserted in the same cycle.
- b_tick and an rx edge in the same cycle: the edge is seen SYNC_STAGES cycles later. This is acceptable at 651 clk per tick.
- Reset asserted mid-frame discards the partial frame immediately and produces no pulse.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH}
  - localparam OVERSAMPLE=16
  - localparam MID_TICK=7
  - localparam LAST_TICK=15
- Sub-module bit_synchronizer (parameter STAGES, reset value 1) contains the rx synchronizer. It is reusable for other async inputs.

Test Plan:
- Valid byte: baud generator at 9600 (651 clk/tick). Send 0xA5, 8N1 → rx_data=0xA5, exactly one rx_done pulse ~10 bit times after the start edge; frame_err stays 0; rx_busy high only during the frame.
- False start: rx low for 4 ticks, then high → no rx_done, no frame_err; FSM returns to IDLE by tick 8; rx_data is unchanged.
- Framing error: after 0xA5, send 0x3C with the stop bit low and rx held low for 3 more bit times → one frame_err pulse, rx_data stays 0xA5, no new frame starts until rx returns high; then 0x5A is received correctly.
- Back-to-back: 0x00, 0xFF, 0x81 with a single stop bit each and no idle gap → three rx_done pulses in order with the matching rx_data values.
- Reset mid-frame: assert rst during data bit 3 of 0xC3 → all outputs go to 0 immediately; after release, 0x7E is received correctly.
- DATA_BITS=7 build: send 0x55 as 7 bits → rx_data=7'h55, one rx_done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [3:0]  MID_TICK   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  LAST_TICK  = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input; resets to 1 (idle-high line).
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 16x oversampled, bit-centre sampling, done/framing-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rx_s;
    logic [3:0]           tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    bit_synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (b_tick) begin
                        if (tick_cnt == MID_TICK) begin
                            // Line back high at the start-bit centre means it was a glitch.
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (b_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == LAST_TICK) begin
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (b_tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == LAST_TICK) begin
                            // Leave at the stop-bit centre so a following start edge is not missed.
                            if (rx_s) begin
                                rx_data <= shreg;
                                rx_done <= 1'b1;
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8-bit and 7-bit builds driven by a fast free-running tick.
module tb_uart_rx;

    localparam int TICK_CLKS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx7 = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, rx_busy;
    logic [6:0] rx_data7;
    logic       rx_done7, frame_err7, rx_busy7;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int done7_cnt = 0;
    int err7_cnt = 0;
    int both_seen = 0;
    logic [7:0] last_data = 8'h00;
    int tick_div = 0;

    uart_rx #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .b_tick   (b_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    uart_rx #(
        .DATA_BITS  (7),
        .SYNC_STAGES(2)
    ) dut7 (
        .clk      (clk),
        .rst      (rst),
        .b_tick   (b_tick),
        .rx       (rx7),
        .rx_data  (rx_data7),
        .rx_done  (rx_done7),
        .frame_err(frame_err7),
        .rx_busy  (rx_busy7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_div == TICK_CLKS - 1) begin
            tick_div <= 0;
            b_tick   <= 1'b1;
        end else begin
            tick_div <= tick_div + 1;
            b_tick   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt  = done_cnt + 1;
            last_data = rx_data;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (rx_done && frame_err) both_seen = both_seen + 1;
        if (rx_done7) done7_cnt = done7_cnt + 1;
        if (frame_err7) err7_cnt = err7_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TICK_CLKS) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_data(d);
        send_bit(stop);
    endtask

    initial begin
        logic [6:0] d7;
        logic [7:0] c3;
        d7 = 7'h55;
        c3 = 8'hC3;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_done", 32'(rx_done), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_rx_busy", 32'(rx_busy), 32'h0);
        check("reset_rx_data7", 32'(rx_data7), 32'h0);
        rst = 1'b0;
        wait_ticks(16);

        // Valid byte 0xA5
        send_bit(1'b0);
        check("a5_busy_mid", 32'(rx_busy), 32'h1);
        send_data(8'hA5);
        send_bit(1'b1);
        check("a5_done_cnt", 32'(done_cnt), 32'd1);
        check("a5_data_seen", 32'(last_data), 32'hA5);
        check("a5_rx_data", 32'(rx_data), 32'hA5);
        check("a5_no_err", 32'(err_cnt), 32'd0);
        check("a5_busy_after", 32'(rx_busy), 32'h0);

        // False start: 4 ticks low
        rx = 1'b0;
        wait_ticks(4);
        check("glitch_busy", 32'(rx_busy), 32'h1);
        rx = 1'b1;
        wait_ticks(16);
        check("glitch_busy_after", 32'(rx_busy), 32'h0);
        check("glitch_done_cnt", 32'(done_cnt), 32'd1);
        check("glitch_err_cnt", 32'(err_cnt), 32'd0);
        check("glitch_rx_data", 32'(rx_data), 32'hA5);

        // Framing error on 0x3C, line held low three more bit times
        send_byte(8'h3C, 1'b0);
        wait_ticks(48);
        check("ferr_err_cnt", 32'(err_cnt), 32'd1);
        check("ferr_done_cnt", 32'(done_cnt), 32'd1);
        check("ferr_rx_data", 32'(rx_data), 32'hA5);
        check("ferr_busy_break", 32'(rx_busy), 32'h1);
        rx = 1'b1;
        wait_ticks(16);
        check("ferr_busy_released", 32'(rx_busy), 32'h0);
        send_byte(8'h5A, 1'b1);
        check("5a_done_cnt", 32'(done_cnt), 32'd2);
        check("5a_rx_data", 32'(rx_data), 32'h5A);
        check("5a_err_cnt", 32'(err_cnt), 32'd1);

        // Back-to-back frames, single stop bit, no gap
        send_byte(8'h00, 1'b1);
        check("b2b_00_data", 32'(last_data), 32'h00);
        send_byte(8'hFF, 1'b1);
        check("b2b_ff_data", 32'(last_data), 32'hFF);
        send_byte(8'h81, 1'b1);
        check("b2b_81_data", 32'(last_data), 32'h81);
        check("b2b_done_cnt", 32'(done_cnt), 32'd5);

        // Reset during data bit 3 of 0xC3
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(c3[i]);
        rx = c3[3];
        wait_ticks(8);
        rst = 1'b1;
        #1;
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        check("midrst_rx_busy", 32'(rx_busy), 32'h0);
        check("midrst_rx_done", 32'(rx_done), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst = 1'b0;
        wait_ticks(16);
        check("midrst_no_pulse", 32'(done_cnt), 32'd5);
        send_byte(8'h7E, 1'b1);
        check("7e_rx_data", 32'(rx_data), 32'h7E);
        check("7e_done_cnt", 32'(done_cnt), 32'd6);

        // 7-bit build: 0x55
        rx7 = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 7; i++) begin
            rx7 = d7[i];
            wait_ticks(16);
        end
        rx7 = 1'b1;
        wait_ticks(16);
        check("d7_rx_data", 32'(rx_data7), 32'h55);
        check("d7_done_cnt", 32'(done7_cnt), 32'd1);
        check("d7_err_cnt", 32'(err7_cnt), 32'd0);

        check("never_done_and_err", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
